bcd_gray_converter: RTL and testbench

//   Registered, bidirectional BCD <-> Gray-code converter for packed BCD digit vectors.

---
 rtl/bcd_gray_pkg.sv | 24 ++
 rtl/bcd_gray_digit.sv | 37 +++
 rtl/bcd_gray_converter.sv | 68 ++++++
 tb/tb_bcd_gray_converter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_gray_pkg.sv
// Shared constants and nibble conversion helpers for the BCD <-> Gray converter.
// The range check is built only when BCDG_ERR_CHECK_EN is defined.
package bcd_gray_pkg;

    localparam int          DIGIT_W  = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic        MODE_B2G = 1'b0;
    localparam logic        MODE_G2B = 1'b1;

    function automatic logic [DIGIT_W-1:0] bin2gray(input logic [DIGIT_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the running XOR of all Gray bits from the MSB down to it.
    function automatic logic [DIGIT_W-1:0] gray2bin(input logic [DIGIT_W-1:0] g);
        logic [DIGIT_W-1:0] b;
        b[DIGIT_W-1] = g[DIGIT_W-1];
        for (int i = DIGIT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bcd_gray_digit.sv
// Combinational single-nibble converter; invalid_o flags a digit outside 0..9.
// With BCDG_ERR_CHECK_EN undefined, invalid_o is a constant 0 and no comparator exists.
module bcd_gray_digit
    import bcd_gray_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               mode_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               invalid_o
);

    logic [DIGIT_W-1:0] conv_w;

    always_comb begin
        if (mode_i == MODE_G2B) begin
            conv_w = gray2bin(digit_i);
        end else begin
            conv_w = bin2gray(digit_i);
        end
    end

    assign digit_o = conv_w;

`ifdef BCDG_ERR_CHECK_EN
    // B2G judges the incoming BCD digit, G2B judges the decoded result.
    always_comb begin
        if (mode_i == MODE_B2G) begin
            invalid_o = (digit_i > BCD_MAX);
        end else begin
            invalid_o = (conv_w > BCD_MAX);
        end
    end
`else
    assign invalid_o = 1'b0;
`endif

endmodule

// File: rtl/bcd_gray_converter.sv
// Registered bidirectional BCD <-> Gray converter over DIGITS packed nibbles, 1-cycle latency.
// Optional per-digit range flag enabled by BCDG_ERR_CHECK_EN.
module bcd_gray_converter
    import bcd_gray_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    mode,
    input  logic [DIGIT_W*DIGITS-1:0] bcd,
    input  logic [DIGIT_W*DIGITS-1:0] gray,
    output logic                    out_valid,
    output logic [DIGIT_W*DIGITS-1:0] out,
    output logic [DIGITS-1:0]       err
);

    localparam int W = DIGIT_W * DIGITS;

    // Valid semantics: in_valid is a one-cycle strobe with no ready; every
    // strobed input produces out_valid exactly one cycle later, out/err hold otherwise.
    logic [W-1:0]      sel_w;
    logic [W-1:0]      conv_w;
    logic [DIGITS-1:0] invalid_w;

    logic [W-1:0]      out_q, out_d;
    logic [DIGITS-1:0] err_q, err_d;
    logic              out_valid_q, out_valid_d;

    assign sel_w = (mode == MODE_G2B) ? gray : bcd;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_gray_digit u_digit (
            .digit_i   (sel_w[k*DIGIT_W +: DIGIT_W]),
            .mode_i    (mode),
            .digit_o   (conv_w[k*DIGIT_W +: DIGIT_W]),
            .invalid_o (invalid_w[k])
        );
    end

    always_comb begin
        out_d       = out_q;
        err_d       = err_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = conv_w;
            err_d = invalid_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_gray_converter.sv
// Self-checking bench for bcd_gray_converter with DIGITS=2 against a table-based reference model.
module tb_bcd_gray_converter;

    localparam int D = 2;
    localparam int W = 4 * D;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         mode;
    logic [W-1:0] bcd;
    logic [W-1:0] gray;
    logic         out_valid;
    logic [W-1:0] out;
    logic [D-1:0] err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W+D-1:0] exp_q[$];
    logic [W-1:0]   last_exp_out;
    logic [D-1:0]   last_exp_err;
    logic [W-1:0]   last_out;
    logic [D-1:0]   last_err;

    int gray_tab[16];
    int inv_tab[16];

    bcd_gray_converter #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .bcd       (bcd),
        .gray      (gray),
        .out_valid (out_valid),
        .out       (out),
        .err       (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: Gray table from the reflected-code rule, inverse by table search
    task automatic build_tables();
        for (int v = 0; v < 16; v++) begin
            gray_tab[v] = v ^ (v / 2);
        end
        for (int v = 0; v < 16; v++) begin
            inv_tab[gray_tab[v]] = v;
        end
    endtask

    function automatic logic [W+D-1:0] model(input bit m, input logic [W-1:0] b, input logic [W-1:0] g);
        logic [W-1:0] o;
        logic [D-1:0] e;
        int           nib;
        int           res;
        o = '0;
        e = '0;
        for (int k = 0; k < D; k++) begin
            nib = m ? int'(g[k*4 +: 4]) : int'(b[k*4 +: 4]);
            res = m ? inv_tab[nib] : gray_tab[nib];
            o[k*4 +: 4] = res[3:0];
`ifdef BCDG_ERR_CHECK_EN
            e[k] = m ? (res > 9) : (nib > 9);
`endif
        end
        return {e, o};
    endfunction

    // driver + scoreboard: drive on negedge, sample #1 after the capturing posedge
    task automatic send(input bit v, input bit m, input logic [W-1:0] b, input logic [W-1:0] g);
        logic [W+D-1:0] exp;
        @(negedge clk);
        in_valid = v;
        mode     = m;
        bcd      = b;
        gray     = g;
        if (v) exp_q.push_back(model(m, b, g));
        @(posedge clk);
        #1;
        last_out = out;
        last_err = err;
        check("out_valid", 32'(out_valid), 32'(v));
        if (v) begin
            exp = exp_q.pop_front();
            last_exp_out = exp[W-1:0];
            last_exp_err = exp[W+D-1:W];
            check("out", 32'(out), 32'(last_exp_out));
            check("err", 32'(err), 32'(last_exp_err));
        end else begin
            check("hold_out", 32'(out), 32'(last_exp_out));
            check("hold_err", 32'(err), 32'(last_exp_err));
        end
        in_valid = 1'b0;
    endtask

    logic [3:0] t2_in[6]  = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd9};
    logic [3:0] t2_exp[6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1101};
    logic [3:0] t3_in[5]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b1100};
    logic [3:0] t3_exp[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        logic [W-1:0] g_rt;
        logic [1:0]   exp_err_a3;
        logic         exp_err_9;
        build_tables();
        rst_n = 1'b1;
        in_valid = 1'b0;
        mode = 1'b0;
        bcd = '0;
        gray = '0;
        last_exp_out = '0;
        last_exp_err = '0;

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("rst_out", 32'(out), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 0, 8'h55, 8'h55);

        for (int i = 0; i < 6; i++) begin
            send(1, 0, {4'h0, t2_in[i]}, 8'hFF);
            check("b2g_dir", 32'(last_out), 32'({4'h0, t2_exp[i]}));
            check("b2g_err", 32'(last_err), 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            send(1, 1, 8'hFF, {4'h0, t3_in[i]});
            check("g2b_dir", 32'(last_out), 32'({4'h0, t3_exp[i]}));
            check("g2b_err", 32'(last_err), 32'h0);
        end

`ifdef BCDG_ERR_CHECK_EN
        exp_err_9  = 1'b1;
        exp_err_a3 = 2'b10;
`else
        exp_err_9  = 1'b0;
        exp_err_a3 = 2'b00;
`endif
        send(1, 1, 8'h00, 8'h09);
        check("g2b_1001_out", 32'(last_out), 32'h0E);
        check("g2b_1001_err", 32'(last_err[0]), 32'(exp_err_9));
        send(1, 0, 8'h59, 8'h00);
        check("b2g_59", 32'(last_out), 32'h7D);
        send(1, 0, 8'hA3, 8'h00);
        check("b2g_a3_out", 32'(last_out), 32'hF2);
        check("b2g_a3_err", 32'(last_err), 32'(exp_err_a3));

        // throughput / hold with alternating mode
        for (int i = 0; i < 32; i++) begin
            send(bit'((i % 3) != 2), bit'(i % 2), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // exhaustive round trip per nibble
        for (int x = 0; x < 16; x++) begin
            send(1, 0, {4'(x), 4'(x)}, 8'($urandom_range(0, 255)));
            g_rt = last_out;
            send(1, 1, 8'($urandom_range(0, 255)), g_rt);
            check("roundtrip", 32'(last_out), 32'({4'(x), 4'(x)}));
        end

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            send(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // reset asserted while a result is pending
        @(negedge clk);
        in_valid = 1'b1;
        mode = 1'b0;
        bcd = 8'h37;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'h0);
        exp_q.delete();
        last_exp_out = '0;
        last_exp_err = '0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        send(0, 0, 8'h12, 8'h34);
        send(1, 1, 8'h00, 8'h2C);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
